// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one data-bus access per load/store and returns the result.
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word accesses raise exc_misalign_o instead of issuing.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  memop_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] sdata_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        exc_misalign_o
);

  localparam int unsigned XW  = 32;
  localparam int unsigned RW  = 5;
  localparam int unsigned OPW = 4;
  localparam int unsigned SW  = 4;

  typedef enum logic {IDLE, REQ} state_t;
  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t          state, state_nxt;
  size_t           size_c;
  logic            is_mem_c;
  logic            misalign_c;
  logic [SW-1:0]   sel_c;
  logic [XW-1:0]   st_c;
  logic [XW-1:0]   ld_c;

  logic            req_nxt, we_nxt;
  logic [XW-1:0]   addr_nxt, bwdata_nxt;
  logic [SW-1:0]   sel_nxt;
  logic [RW-1:0]   wd_nxt;
  logic            wreg_nxt;
  logic [XW-1:0]   wdata_nxt;

  // Access context kept while the bus transaction is outstanding
  logic [OPW-1:0]  memop_q, memop_nxt;
  logic [1:0]      lane_q, lane_nxt;
  logic [RW-1:0]   wd_q, wd_q_nxt;
  logic            wreg_q, wreg_q_nxt;

  // Access size decode; every other opcode is a plain ALU result
  always_comb begin
    size_c = SZ_NONE;
    case (memop_i)
      4'b0001, 4'b0010, 4'b1001: size_c = SZ_BYTE;
      4'b0011, 4'b0100, 4'b1011: size_c = SZ_HALF;
      4'b0101, 4'b1101:          size_c = SZ_WORD;
      default:                   size_c = SZ_NONE;
    endcase
  end

  assign is_mem_c = (size_c != SZ_NONE);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_c = ((size_c == SZ_HALF) && addr_i[0]) ||
                      ((size_c == SZ_WORD) && (addr_i[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst) exc_misalign_o <= 1'b0;
    else     exc_misalign_o <= (state == IDLE) && misalign_c;
  end
`else
  assign misalign_c     = 1'b0;
  assign exc_misalign_o = 1'b0;
`endif

  // Big-endian byte lanes; stores replicate the datum across every lane
  always_comb begin
    sel_c = 4'b0000;
    st_c  = '0;
    case (size_c)
      SZ_BYTE: begin
        sel_c = 4'b1000 >> addr_i[1:0];
        st_c  = {4{sdata_i[7:0]}};
      end
      SZ_HALF: begin
        sel_c = addr_i[1] ? 4'b0011 : 4'b1100;
        st_c  = {2{sdata_i[15:0]}};
      end
      SZ_WORD: begin
        sel_c = 4'b1111;
        st_c  = sdata_i;
      end
      default: ;
    endcase
    if (!memop_i[3]) st_c = '0;
  end

  // Load lane extraction and extension from the latched opcode and address
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    case (lane_q)
      2'd0:    b = dbus_rdata_i[31:24];
      2'd1:    b = dbus_rdata_i[23:16];
      2'd2:    b = dbus_rdata_i[15:8];
      default: b = dbus_rdata_i[7:0];
    endcase
    h = lane_q[1] ? dbus_rdata_i[15:0] : dbus_rdata_i[31:16];
    case (memop_q)
      4'b0001: ld_c = {{24{b[7]}}, b};
      4'b0010: ld_c = {24'd0, b};
      4'b0011: ld_c = {{16{h[15]}}, h};
      4'b0100: ld_c = {16'd0, h};
      4'b0101: ld_c = dbus_rdata_i;
      default: ld_c = '0;
    endcase
  end

  assign stallreq_o = (state == IDLE) ? (is_mem_c && !misalign_c) : !dbus_ack_i;

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    req_nxt    = dbus_req_o;
    we_nxt     = dbus_we_o;
    addr_nxt   = dbus_addr_o;
    sel_nxt    = dbus_sel_o;
    bwdata_nxt = dbus_wdata_o;
    wd_nxt     = '0;
    wreg_nxt   = 1'b0;
    wdata_nxt  = '0;
    memop_nxt  = memop_q;
    lane_nxt   = lane_q;
    wd_q_nxt   = wd_q;
    wreg_q_nxt = wreg_q;
    case (state)
      IDLE: begin
        if (is_mem_c && !misalign_c) begin
          state_nxt  = REQ;
          req_nxt    = 1'b1;
          we_nxt     = memop_i[3];
          addr_nxt   = {addr_i[31:2], 2'b00};
          sel_nxt    = sel_c;
          bwdata_nxt = st_c;
          memop_nxt  = memop_i;
          lane_nxt   = addr_i[1:0];
          wd_q_nxt   = wd_i;
          wreg_q_nxt = wreg_i;
        end else if (!is_mem_c) begin
          wd_nxt    = wd_i;
          wreg_nxt  = wreg_i;
          wdata_nxt = wdata_i;
        end
      end
      REQ: begin
        if (dbus_ack_i) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          if (!memop_q[3]) begin
            wd_nxt    = wd_q;
            wreg_nxt  = wreg_q;
            wdata_nxt = ld_c;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_sel_o   <= '0;
      dbus_wdata_o <= '0;
      wd_o         <= '0;
      wreg_o       <= 1'b0;
      wdata_o      <= '0;
      memop_q      <= '0;
      lane_q       <= '0;
      wd_q         <= '0;
      wreg_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      dbus_req_o   <= req_nxt;
      dbus_we_o    <= we_nxt;
      dbus_addr_o  <= addr_nxt;
      dbus_sel_o   <= sel_nxt;
      dbus_wdata_o <= bwdata_nxt;
      wd_o         <= wd_nxt;
      wreg_o       <= wreg_nxt;
      wdata_o      <= wdata_nxt;
      memop_q      <= memop_nxt;
      lane_q       <= lane_nxt;
      wd_q         <= wd_q_nxt;
      wreg_q       <= wreg_q_nxt;
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 wd_i  in  5  destination register address from EX/MEM register.
REQ-004 wreg_i  in  1  register-write enable from EX/MEM register.
REQ-005 wdata_i  in  32  ALU result (used for non-load ops).
REQ-006 memop_i  in  4  memory op: 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW, 1001 SB, 1011 SH, 1101 SW; any other code is non-memory.
REQ-007 addr_i  in  32  effective address; sdata_i  in  32  store data.
REQ-008 dbus_req_o  out  1 | dbus_we_o  out  1 | dbus_addr_o  out  32 | dbus_sel_o  out  4 | dbus_wdata_o  out  32  data-bus request, all registered.
REQ-009 dbus_ack_i  in  1 | dbus_rdata_i  in  32  data-bus completion and read data.
REQ-010 wd_o  out  5 | wreg_o  out  1 | wdata_o  out  32  registered results to MEM/WB register.
REQ-011 stallreq_o  out  1  combinational pipeline stall request.
REQ-012 exc_misalign_o  out  1  registered one-cycle misalignment pulse.

Function
REQ-013 FSM states SHALL be IDLE and REQ.
REQ-014 IDLE, non-memory op: next edge wd_o/wreg_o/wdata_o SHALL take wd_i/wreg_i/wdata_i (1-cycle latency); stallreq_o=0.
REQ-015 IDLE, memory op: next edge SHALL enter REQ, set dbus_req_o=1, latch dbus_addr_o={addr_i[31:2],2'b00}, dbus_we_o=memop_i[3], dbus_sel_o, dbus_wdata_o, wd/wreg; outputs SHALL carry a bubble (wreg_o=0, wd_o=0, wdata_o=0).
REQ-016 Byte lanes SHALL be big-endian: byte addr[1:0]=00->sel 1000 (bits 31:24) ... 11->0001; half addr[1]=0->1100, 1->0011; word->1111.
REQ-017 Stores SHALL replicate the byte/half of sdata_i into every lane; loads SHALL drive dbus_wdata_o=0.
REQ-018 stallreq_o SHALL equal (IDLE and memory op) or (REQ and not dbus_ack_i).
REQ-019 REQ: request fields SHALL hold stable until dbus_ack_i; on ack edge return to IDLE with dbus_req_o=0.
REQ-020 On load ack, wdata_o SHALL take the selected lane, sign-extended for LB/LH, zero-extended for LBU/LHU, whole word for LW; wreg_o/wd_o take latched values.
REQ-021 On store ack, wreg_o SHALL be 0, wd_o 0, wdata_o 0.
REQ-022 dbus_ack_i while IDLE SHALL be ignored.
REQ-023 Because stallreq_o falls in the ack cycle, the next op presented in IDLE SHALL be a new instruction; no memory op is issued twice.

Reset
REQ-024 rst SHALL force IDLE, dbus_req_o=0, dbus_we_o=0, dbus_addr_o=0, dbus_sel_o=0, dbus_wdata_o=0, wd_o=0, wreg_o=0, wdata_o=0, exc_misalign_o=0.
REQ-025 rst during REQ SHALL abandon the access; no result SHALL be written and a later ack SHALL be ignored.

Configuration
REQ-026 With MEM_ALIGN_CHECK_EN defined: half access with addr_i[0]=1 or word access with addr_i[1:0]!=00 SHALL not issue a request, SHALL stay IDLE, stallreq_o=0, and next edge SHALL pulse exc_misalign_o=1 for one cycle with a bubble output.
REQ-027 Without MEM_ALIGN_CHECK_EN: misaligned low address bits SHALL be ignored (half uses addr[1], word forced aligned) and exc_misalign_o SHALL be tied 0.

Verification
REQ-028 ADD wd=3 wreg=1 wdata=0x12345678 -> next cycle wd_o=3 wreg_o=1 wdata_o=0x12345678, stallreq_o=0.
REQ-029 LB addr=0x101 rdata=0x00F10000, ack after 3 wait cycles -> stallreq high 4 cycles, sel=0100, wdata_o=0xFFFFFFF1; LBU gives 0x000000F1.
REQ-030 SH addr=0x202 sdata=0xAAAABEEF -> dbus_we_o=1 addr=0x200 sel=0011 wdata=0xBEEFBEEF; on ack wreg_o=0.
REQ-031 LW issued, rst asserted in REQ, ack next cycle -> all outputs 0, no write, state IDLE.
REQ-032 LW addr=0x103 with MEM_ALIGN_CHECK_EN -> no dbus_req_o, exc_misalign_o one-cycle pulse; without macro -> request at 0x100 sel=1111.
REQ-033 Back-to-back LW then SW with single-cycle acks -> each issued exactly once, in order.
